// File: rtl/wave_sched_pkg.sv
// Shared types and word layout for the round-robin waveform scheduler.
// A queue word packs qsel/ctrl/wait/addr from MSB to LSB.
package wave_sched_pkg;

    localparam int GW       = 80;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 32;
    localparam int WAIT_LSB = 32;
    localparam int WAIT_W   = 32;
    localparam int CTRL_LSB = 64;
    localparam int CTRL_W   = 8;
    localparam int QSEL_LSB = 72;
    localparam int QSEL_W   = 8;

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        READ  = 6'b000010,
        REGS  = 6'b000100,
        START = 6'b001000,
        BUSY  = 6'b010000,
        GAP   = 6'b100000
    } state_t;

    typedef struct packed {
        logic [QSEL_W-1:0] qsel;
        logic [CTRL_W-1:0] ctrl;
        logic [WAIT_W-1:0] wcyc;
        logic [ADDR_W-1:0] addr;
    } wave_word_t;

    function automatic wave_word_t unpack_word(input logic [GW-1:0] w);
        wave_word_t r;
        r.addr = w[ADDR_LSB +: ADDR_W];
        r.wcyc = w[WAIT_LSB +: WAIT_W];
        r.ctrl = w[CTRL_LSB +: CTRL_W];
        r.qsel = w[QSEL_LSB +: QSEL_W];
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: highest priority is (last + 1) mod N,
// wrapping through the remaining requesters.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt,
    output logic          vld
);

    logic [IW-1:0] idx;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N);
            if (req[idx]) begin
                gnt = idx;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_sched_rr.sv
// Shares one waveform generator among N queues: grant, read one word,
// launch the generator, then hold off for the word's wait count.
module wave_sched_rr #(
    parameter int N  = 4,
    parameter int GW = wave_sched_pkg::GW,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [N-1:0]    fifo_rd_en,
    input  logic [N-1:0]    fifo_empty,
    input  logic [N*GW-1:0] fifo_dout,
    output logic            start,
    input  logic            busy,
    output logic [31:0]     addr_o,
    output logic [31:0]     wait_o,
    output logic [7:0]      ctrl_o,
    output logic [7:0]      qsel_o,
    output logic [IW-1:0]   gnt_o,
    output logic            idle_o
);
    import wave_sched_pkg::*;

    state_t        state, state_nxt;
    logic [IW-1:0] last_q;
    logic [IW-1:0] arb_gnt;
    logic          arb_vld;
    logic [31:0]   cnt;
    logic [GW-1:0] words [N];
    wave_word_t    cur;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign words[i] = fifo_dout[i*GW +: GW];
    end

    assign cur = unpack_word(words[gnt_o]);

    rr_arbiter #(.N(N)) u_arb (
        .req  (~fifo_empty),
        .last (last_q),
        .gnt  (arb_gnt),
        .vld  (arb_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Strobes are masked by rst so nothing leaks out while reset is held.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = '0;
        start      = 1'b0;
        unique case (state)
            IDLE:  if (en && arb_vld) state_nxt = READ;
            READ: begin
                fifo_rd_en[gnt_o] = ~rst;
                state_nxt         = REGS;
            end
            REGS:  state_nxt = START;
            START: begin
                start = ~rst;
                if (busy) state_nxt = BUSY;
            end
            BUSY:  if (!busy) state_nxt = (wait_o == '0) ? IDLE : GAP;
            GAP:   if (cnt == 32'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IW'(N-1);
            gnt_o  <= '0;
            addr_o <= '0;
            wait_o <= '0;
            ctrl_o <= '0;
            qsel_o <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (en && arb_vld) begin
                    gnt_o  <= arb_gnt;
                    last_q <= arb_gnt;
                end
                // FIFO data is valid one cycle after the READ strobe.
                REGS: begin
                    addr_o <= cur.addr;
                    wait_o <= cur.wcyc;
                    ctrl_o <= cur.ctrl;
                    qsel_o <= cur.qsel;
                end
                BUSY: if (!busy && wait_o != '0) cnt <= wait_o;
                GAP:  cnt <= cnt - 32'd1;
                default: ;
            endcase
        end
    end

    assign idle_o = (state == IDLE);

endmodule
